// File: rtl/receiver_if.sv
// Signal bundle between the UART receive engine and its tick source, serial pad and consumer.
interface receiver_if;
   localparam int unsigned WORD_W = 8;

   logic              s_tick;
   logic              rx;
   logic [WORD_W-1:0] rx_dout;
   logic              rx_done_tick;
   logic              frame_err;

   modport master (
      output s_tick,
      output rx,
      input  rx_dout,
      input  rx_done_tick,
      input  frame_err
   );

   modport slave (
      input  s_tick,
      input  rx,
      output rx_dout,
      output rx_done_tick,
      output frame_err
   );
endinterface

// File: rtl/receiver.sv
// UART receive engine: 16x oversampled start/data/stop recovery with registered
// parallel word, one-cycle done strobe and framing-error flag.
module receiver #(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16
) (
   input  logic      clk,
   input  logic      reset_n,
   receiver_if.slave rx_if
);
   localparam int unsigned WORD_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned BIT_W  = 3;

   localparam logic [CNT_W-1:0] START_MID = CNT_W'(7);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(15);
   localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(SB_TICK - 1);
   localparam logic [BIT_W-1:0] N_LAST    = BIT_W'(DBIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e            state_q, state_d;
   logic [1:0]        sync_q;
   logic              rx_prev_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [BIT_W-1:0]  n_q, n_d;
   logic [WORD_W-1:0] b_reg_q, b_reg_d;
   logic [WORD_W-1:0] dout_q, dout_d;
   logic              done_q, done_d;
   logic              ferr_q, ferr_d;
   logic              rx_sync;
   logic              fall;

   assign rx_sync = sync_q[1];
   assign fall    = rx_prev_q & ~rx_sync;

   // Next-state: idle edge detect is ungated; every other step waits for s_tick.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      n_d     = n_q;
      b_reg_d = b_reg_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      ferr_d  = ferr_q;
      case (state_q)
         S_IDLE: begin
            if (fall) begin
               count_d = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (rx_if.s_tick) begin
               if (count_q == START_MID) begin
                  if (!rx_sync) begin
                     count_d = '0;
                     n_d     = '0;
                     state_d = S_DATA;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (rx_if.s_tick) begin
               if (count_q == BIT_LAST) begin
                  count_d = '0;
                  b_reg_d = {rx_sync, b_reg_q[WORD_W-1:1]};
                  if (n_q == N_LAST) begin
                     state_d = S_STOP;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         S_STOP: begin
            if (rx_if.s_tick) begin
               if (count_q == STOP_LAST) begin
                  // Shifted in from the top, so a short word sits left-aligned.
                  dout_d  = b_reg_q >> (WORD_W - DBIT);
                  ferr_d  = ~rx_sync;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= 2'b11;
         rx_prev_q <= 1'b1;
         state_q   <= S_IDLE;
         count_q   <= '0;
         n_q       <= '0;
         b_reg_q   <= '0;
         dout_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], rx_if.rx};
         rx_prev_q <= rx_sync;
         state_q   <= state_d;
         count_q   <= count_d;
         n_q       <= n_d;
         b_reg_q   <= b_reg_d;
         dout_q    <= dout_d;
         done_q    <= done_d;
         ferr_q    <= ferr_d;
      end
   end

   assign rx_if.rx_dout      = dout_q;
   assign rx_if.rx_done_tick = done_q;
   assign rx_if.frame_err    = ferr_q;
endmodule

// File: doc/receiver.md
# receiver

UART receive engine, 8N1-style framing with parameterised data width and stop duration, 16x oversampling. It shares the baud-rate tick source (`s_tick`) with the transmit engine and recovers the byte stream from the serial line `rx`. The line is synchronised, the start bit is validated, each bit is sampled at mid-bit, and the result is presented as a parallel word with a one-cycle done strobe and a framing-error flag. It sits between the pad and the receive FIFO/consumer logic.

## Interface
- `DBIT`, 8: data bits per frame (1..8), LSB first.
- `SB_TICK`, 16: s_ticks spent in stop state before sampling (16 = 1 stop bit).
- `clk` input 1: sole clock, all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `s_tick` input 1: one-`clk` enable pulse at 16x baud rate.
- `rx` input 1: asynchronous serial line, idle high.
- `rx_dout` output 8: received word, right-aligned; bits above DBIT-1 are 0.
- `rx_done_tick` output 1: one-`clk` pulse, frame complete.
- `frame_err` output 1: stop bit sampled low for the frame just completed.

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_sync`, both flops reset to 1), then one more flop `rx_prev` for edge detect (reset 1).
- State register: s_idle, s_start, s_data, s_stop; 4-bit tick counter `count`, 3-bit bit counter `n`, 8-bit shift register `b_reg`.
- s_idle: when `rx_prev`=1 and `rx_sync`=0 (falling edge), count←0, go s_start. Not gated by `s_tick`. A line already low on leaving reset or after a frame is NOT a start.
- s_start: on each `s_tick`, if count==7: if `rx_sync`=0 → count←0, n←0, go s_data; else (glitch) → go s_idle, no output. Otherwise count←count+1.
- s_data: on each `s_tick`, if count==15: count←0, b_reg←{rx_sync, b_reg[7:1]}; if n==DBIT-1 go s_stop else n←n+1. Otherwise count←count+1.
- s_stop: on each `s_tick`, if count==SB_TICK-1: rx_dout←b_reg >> (8-DBIT), frame_err←~rx_sync, rx_done_tick pulses, go s_idle. Otherwise count←count+1.
- Data is delivered even when frame_err=1; consumer decides.
- `rx_dout` and `frame_err` hold until the next completed frame.
- Unused state encodings go to s_idle.
- No `s_tick` means no progress; counters and state hold.

## Timing
- Reset values: rx_dout=0x00, rx_done_tick=0, frame_err=0, state s_idle, count=0, n=0, b_reg=0.
- Reset asserted mid-frame: immediate abort to reset values, no done pulse; a new frame needs a fresh falling edge after reset release.
- Edge detect latency: start recognised 3 `clk` after `rx` falls (2 sync + 1 edge flop).
- Start validated 8 s_ticks after entry (mid start bit); data bit k sampled 16·(k+1) s_ticks later (mid-bit); stop sampled SB_TICK s_ticks after last data sample.
- rx_done_tick, rx_dout and frame_err are registered: all update on the `clk` edge following the final stop `s_tick` and are valid together for that cycle; pulse width exactly one `clk`.
- State returns to s_idle in the same cycle; a start edge arriving during the remaining half stop bit is detected normally (back-to-back frames supported).
- Break (line held low): one frame with rx_dout=0x00, frame_err=1, then no further frames until `rx` returns high and falls again.

## Test plan
- Bench: `s_tick` every 4 clk, model TX drives `rx` at 64 clk/bit. Send 0xA5, 1 stop → exactly one rx_done_tick, rx_dout=0xA5, frame_err=0.
- Back-to-back 0x00 then 0xFF, no idle gap → two done pulses, rx_dout 0x00 then 0xFF, frame_err=0 both.
- `rx` low for 3 s_ticks then high → no rx_done_tick, FSM back to s_idle; following 0x3C frame received correctly.
- Frame 0x5A with stop bit driven low → rx_done_tick, rx_dout=0x5A, frame_err=1; next good frame 0x11 clears frame_err to 0.
- Hold `rx` low 20 bit times then high, then send 0x7E → exactly two done pulses: 0x00/frame_err=1, then 0x7E/frame_err=0.
- Assert reset_n low during data bit 4 of 0xC3 → outputs return to reset values immediately, no done pulse; after release, 0x81 received correctly. Repeat with DBIT=7, frame 0x55 → rx_dout=0x55.
